fetch_decode_unit: RTL and testbench

- Instruction fetch and decode stage directly upstream of the register file.
- Owns the program counter and drives a synchronous-read instruction ROM.
- Latches each 9-bit instruction and splits it into the fields the register file consumes: OpCode, Function, Regaddr, OpReg and Imm.
- Generates the register-file WriteEn pulse, resolves branches reported by the ALU, and signals program completion.

---
 rtl/fetch_decode_unit_if.sv | 31 +++
 rtl/fetch_decode_unit.sv | 93 +++++++++
 tb/tb_fetch_decode_unit.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/fetch_decode_unit_if.sv
// Bundle between the fetch/decode stage and its ROM, ALU branch resolver and register file.
// "master" is the fetch/decode side; "slave" is everything it talks to.
interface fetch_decode_unit_if #(
  parameter int PW = 8,
  parameter int IW = 9,
  parameter int D  = 4
);
  logic          Start;
  logic [PW-1:0] InstrAddr;
  logic [IW-1:0] InstrIn;
  logic          BranchTaken;
  logic [PW-1:0] BranchTarget;
  logic [1:0]    OpCode;
  logic [1:0]    Function;
  logic          OpReg;
  logic [D-1:0]  Regaddr;
  logic [7:0]    Imm;
  logic          WriteEn;
  logic [PW-1:0] PC;
  logic          Done;

  modport master (
    input  Start, InstrIn, BranchTaken, BranchTarget,
    output InstrAddr, OpCode, Function, OpReg, Regaddr, Imm, WriteEn, PC, Done
  );

  modport slave (
    output Start, InstrIn, BranchTaken, BranchTarget,
    input  InstrAddr, OpCode, Function, OpReg, Regaddr, Imm, WriteEn, PC, Done
  );
endinterface

// File: rtl/fetch_decode_unit.sv
// Fetch/decode stage: owns the PC, reads a synchronous ROM, latches the instruction
// and splits it into register-file fields, with branch resolution and halt detection.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | after reset; waiting for Start
// S_FETCH | PC presented to the ROM
// S_LOAD  | ROM data valid; captured into IR at the end of the cycle
// S_EXEC  | decoded fields valid; write strobe, branch or halt resolved
// S_HALT  | program finished; Done held until Start
module fetch_decode_unit #(
  parameter int            PW       = 8,
  parameter int            IW       = 9,
  parameter int            D        = 4,
  parameter logic [PW-1:0] START_PC = '0
) (
  input logic                  Clk,
  input logic                  Reset,
  fetch_decode_unit_if.master  bus
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_LOAD  = 3'd2;
  localparam logic [2:0] S_EXEC  = 3'd3;
  localparam logic [2:0] S_HALT  = 3'd4;

  logic [2:0]    state;
  logic [PW-1:0] pc;
  logic [IW-1:0] ir;
  logic          done;
  logic          is_halt;
  logic          is_branch;

  assign is_halt   = &ir;
  assign is_branch = (ir[8:5] == 4'b0111);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= S_IDLE;
      pc    <= '0;
      ir    <= '0;
      done  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.Start) begin
            pc    <= START_PC;
            state <= S_FETCH;
          end
        end
        S_FETCH: state <= S_LOAD;
        S_LOAD: begin
          ir    <= bus.InstrIn;
          state <= S_EXEC;
        end
        S_EXEC: begin
          if (is_halt) begin
            done  <= 1'b1;
            state <= S_HALT;
          end else begin
            if (is_branch && bus.BranchTaken)
              pc <= bus.BranchTarget;
            else
              pc <= pc + 1'b1;
            state <= S_FETCH;
          end
        end
        S_HALT: begin
          if (bus.Start) begin
            done  <= 1'b0;
            pc    <= START_PC;
            state <= S_FETCH;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Gated by Reset so a reset landing in EXEC never produces a write.
  assign bus.WriteEn   = (state == S_EXEC) && !is_halt && !is_branch && !Reset;

  assign bus.InstrAddr = pc;
  assign bus.PC        = pc;
  assign bus.Done      = done;
  assign bus.OpCode    = ir[8:7];
  assign bus.Function  = ir[6:5];
  assign bus.OpReg     = ir[4];
  assign bus.Regaddr   = ir[D-1:0];
  assign bus.Imm       = ir[7:0];

endmodule

// File: tb/tb_fetch_decode_unit.sv
// Bench for fetch_decode_unit: directed programs plus random ROM programs, checked by an
// instruction-level interpreter that predicts PC flow, decoded fields and write strobes.
module tb_fetch_decode_unit;

  logic Clk;
  logic Reset;

  fetch_decode_unit_if bus ();

  fetch_decode_unit dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  logic [8:0] rom [256];
  int         checks   = 0;
  int         failures = 0;
  logic [7:0] m_pc;
  logic       m_done;

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  always @(posedge Clk) bus.InstrIn <= rom[bus.InstrAddr];

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic step;
    @(posedge Clk);
    #1;
  endtask

  task automatic start_prog;
    bus.Start = 1'b1;
    step;
    bus.Start = 1'b0;
    m_pc   = 8'h00;
    m_done = 1'b0;
  endtask

  // One instruction: FETCH, LOAD, EXEC, starting just after the edge that enters FETCH.
  task automatic exec_instr(input logic bt, input logic [7:0] tgt, input bit rnd_start);
    logic [8:0] w;
    logic       br;
    logic       hlt;
    w   = rom[m_pc];
    br  = (w[8:7] == 2'd1) && (w[6:5] == 2'd3);
    hlt = (w == 9'h1FF);
    check_val("fetch_addr", 32'(bus.InstrAddr), 32'(m_pc));
    check_val("fetch_pc", 32'(bus.PC), 32'(m_pc));
    check_val("fetch_we", 32'(bus.WriteEn), 32'd0);
    check_val("fetch_done", 32'(bus.Done), 32'd0);
    if (rnd_start) bus.Start = 1'($urandom_range(0, 1));
    step;
    check_val("load_we", 32'(bus.WriteEn), 32'd0);
    check_val("load_addr", 32'(bus.InstrAddr), 32'(m_pc));
    step;
    check_val("exec_opcode", 32'(bus.OpCode), 32'(w[8:7]));
    check_val("exec_func", 32'(bus.Function), 32'(w[6:5]));
    check_val("exec_opreg", 32'(bus.OpReg), 32'(w[4]));
    check_val("exec_regaddr", 32'(bus.Regaddr), 32'(w[3:0]));
    check_val("exec_imm", 32'(bus.Imm), 32'(w[7:0]));
    check_val("exec_we", 32'(bus.WriteEn), 32'(!br && !hlt));
    bus.BranchTaken  = bt;
    bus.BranchTarget = tgt;
    step;
    bus.BranchTaken  = 1'b0;
    bus.BranchTarget = 8'h00;
    bus.Start        = 1'b0;
    if (hlt)            m_done = 1'b1;
    else if (br && bt)  m_pc = tgt;
    else                m_pc = m_pc + 8'd1;
    if (hlt) begin
      check_val("halt_done", 32'(bus.Done), 32'd1);
      check_val("halt_pc", 32'(bus.PC), 32'(m_pc));
      check_val("halt_we", 32'(bus.WriteEn), 32'd0);
    end
  endtask

  function automatic logic [8:0] rand_word();
    int         r;
    logic [8:0] w;
    r = $urandom_range(0, 99);
    if (r < 20) return {4'b0111, 4'($urandom)};
    if (r < 24) return 9'h1FF;
    do w = 9'($urandom); while (w == 9'h1FF || w[8:5] == 4'b0111);
    return w;
  endfunction

  initial begin
    Reset            = 1'b1;
    bus.Start        = 1'b0;
    bus.BranchTaken  = 1'b0;
    bus.BranchTarget = 8'h00;
    for (int i = 0; i < 256; i++) rom[i] = 9'h000;
    m_pc   = 8'h00;
    m_done = 1'b0;
    step;
    step;
    check_val("rst_pc", 32'(bus.PC), 32'd0);
    check_val("rst_addr", 32'(bus.InstrAddr), 32'd0);
    check_val("rst_done", 32'(bus.Done), 32'd0);
    check_val("rst_we", 32'(bus.WriteEn), 32'd0);
    check_val("rst_opcode", 32'(bus.OpCode), 32'd0);
    check_val("rst_imm", 32'(bus.Imm), 32'd0);
    check_val("rst_regaddr", 32'(bus.Regaddr), 32'd0);
    Reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step;
      check_val("idle_we", 32'(bus.WriteEn), 32'd0);
      check_val("idle_pc", 32'(bus.PC), 32'd0);
    end

    // straight-line program ending in halt
    rom[0] = 9'h105;
    rom[1] = 9'h0A3;
    rom[2] = 9'h033;
    rom[3] = 9'h1FF;
    start_prog;
    for (int i = 0; i < 4; i++) exec_instr(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step;
      check_val("hold_done", 32'(bus.Done), 32'd1);
      check_val("hold_pc", 32'(bus.PC), 32'd3);
      check_val("hold_we", 32'(bus.WriteEn), 32'd0);
    end

    // branches, taken and not taken, and PC wrap at 8'hFF
    rom[8'h00] = 9'h0E4;
    rom[8'h04] = 9'h0E9;
    rom[8'h20] = 9'h0EA;
    rom[8'h21] = 9'h0E0;
    rom[8'hFF] = 9'h0A5;
    rom[8'h01] = 9'h1FF;
    start_prog;
    check_val("restart_done", 32'(bus.Done), 32'd0);
    check_val("restart_pc", 32'(bus.PC), 32'd0);
    exec_instr(1'b1, 8'h04, 1'b0);
    exec_instr(1'b1, 8'h20, 1'b0);
    exec_instr(1'b0, 8'h33, 1'b0);
    exec_instr(1'b1, 8'hFF, 1'b0);
    exec_instr(1'b1, 8'h55, 1'b0);
    check_val("wrap_pc", 32'(bus.PC), 32'd0);
    exec_instr(1'b0, 8'h00, 1'b0);
    exec_instr(1'b0, 8'h00, 1'b0);

    // reset during LOAD of a writing instruction
    rom[0] = 9'h045;
    start_prog;
    step;
    Reset = 1'b1;
    #1;
    check_val("rstload_we", 32'(bus.WriteEn), 32'd0);
    step;
    Reset = 1'b0;
    check_val("rstload_pc", 32'(bus.PC), 32'd0);
    check_val("rstload_done", 32'(bus.Done), 32'd0);
    for (int i = 0; i < 4; i++) begin
      check_val("rstload_idle_we", 32'(bus.WriteEn), 32'd0);
      check_val("rstload_idle_pc", 32'(bus.PC), 32'd0);
      step;
    end

    // reset landing in EXEC must suppress the write strobe
    start_prog;
    step;
    step;
    check_val("exec_we_pre", 32'(bus.WriteEn), 32'd1);
    Reset = 1'b1;
    #1;
    check_val("rstexec_we", 32'(bus.WriteEn), 32'd0);
    step;
    Reset = 1'b0;
    check_val("rstexec_pc", 32'(bus.PC), 32'd0);
    check_val("rstexec_we_after", 32'(bus.WriteEn), 32'd0);

    // random programs
    for (int p = 0; p < 4; p++) begin
      for (int i = 0; i < 256; i++) rom[i] = rand_word();
      start_prog;
      for (int n = 0; n < 40 && !m_done; n++)
        exec_instr(1'($urandom_range(0, 1)), 8'($urandom), 1'b1);
      if (!m_done) begin
        Reset = 1'b1;
        step;
        Reset = 1'b0;
        check_val("rnd_rst_pc", 32'(bus.PC), 32'd0);
        check_val("rnd_rst_done", 32'(bus.Done), 32'd0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
